// File: rtl/seq_lock_param.sv
// Parametrised two-button sequence lock with a reprogrammable code,
// failed-attempt lockout and an entry inactivity timeout.
module seq_lock_param #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b0110,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 64,
  parameter int                  TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          RESET_Button,
  input  logic                          ZERO_Button,
  input  logic                          ONE_Button,
  input  logic                          PROG_Button,
  input  logic                          LOCK_Button,
  output logic                          UNLOCK_Output,
  output logic                          LOCKOUT_Output,
  output logic                          FAIL_Pulse,
  output logic [$clog2(CODE_LEN+1)-1:0] DIGIT_Count
);

  localparam int DW = $clog2(CODE_LEN+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam int LW = $clog2(LOCKOUT_CYCLES+1);

  localparam logic [DW-1:0] LAST_DIG = DW'(CODE_LEN-1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES-1);
  localparam logic [LW-1:0] LO_LAST  = LW'(LOCKOUT_CYCLES-1);
  localparam logic [3:0]    FAIL_MAX = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_ENTRY,
    S_UNLOCKED,
    S_PROGRAM,
    S_LOCKOUT
  } state_t;

  state_t              state_q;
  logic [3:0]          btn_q;
  logic [CODE_LEN-1:0] code_q;
  logic [CODE_LEN-1:0] cmp_q;
  logic [CODE_LEN-2:0] stage_q;
  logic [DW-1:0]       cnt_q;
  logic [TW-1:0]       tmr_q;
  logic [LW-1:0]       lo_q;
  logic [3:0]          fcnt_q;
  logic                mis_q;
  logic                unlock_q;
  logic                lockout_q;
  logic                fail_q;

  logic [3:0] btn_in;
  logic [3:0] ev;
  logic       dig_ev;
  logic       dig;
  logic       exp_bit;
  logic       mis_d;
  logic       idle_to;
  logic [3:0] fcnt_d;

  assign btn_in  = {PROG_Button, LOCK_Button, ONE_Button, ZERO_Button};
  assign ev      = btn_in & ~btn_q;
  // Simultaneous ZERO and ONE edges cancel out.
  assign dig_ev  = ev[0] ^ ev[1];
  assign dig     = ev[1];
  assign exp_bit = (state_q == S_LOCKED) ? code_q[CODE_LEN-1]
                                         : cmp_q[CODE_LEN-1];
  assign mis_d   = mis_q | (dig != exp_bit);
  assign idle_to = (tmr_q == TO_LAST);
  assign fcnt_d  = (fcnt_q == 4'hF) ? fcnt_q : fcnt_q + 4'd1;

  always_ff @(posedge clk or posedge RESET_Button) begin
    if (RESET_Button) begin
      state_q   <= S_LOCKED;
      btn_q     <= '0;
      code_q    <= DEFAULT_CODE;
      cmp_q     <= '0;
      stage_q   <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      lo_q      <= '0;
      fcnt_q    <= '0;
      mis_q     <= 1'b0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      btn_q  <= btn_in;
      fail_q <= 1'b0;
      unique case (state_q)
        S_LOCKED: begin
          if (dig_ev) begin
            state_q <= S_ENTRY;
            cnt_q   <= DW'(1);
            mis_q   <= mis_d;
            cmp_q   <= code_q << 1;
            tmr_q   <= '0;
          end
        end
        S_ENTRY: begin
          if (dig_ev) begin
            tmr_q <= '0;
            if (cnt_q == LAST_DIG) begin
              cnt_q <= '0;
              mis_q <= 1'b0;
              if (!mis_d) begin
                state_q  <= S_UNLOCKED;
                unlock_q <= 1'b1;
                fcnt_q   <= '0;
              end else begin
                fail_q <= 1'b1;
                fcnt_q <= fcnt_d;
                if (fcnt_d == FAIL_MAX) begin
                  state_q   <= S_LOCKOUT;
                  lockout_q <= 1'b1;
                  lo_q      <= '0;
                end else begin
                  state_q <= S_LOCKED;
                end
              end
            end else begin
              cnt_q <= cnt_q + DW'(1);
              mis_q <= mis_d;
              cmp_q <= cmp_q << 1;
            end
          end else if (idle_to) begin
            state_q <= S_LOCKED;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_UNLOCKED: begin
          if (ev[2]) begin
            state_q  <= S_LOCKED;
            unlock_q <= 1'b0;
          end else if (ev[3]) begin
            state_q  <= S_PROGRAM;
            unlock_q <= 1'b0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            stage_q  <= '0;
          end
        end
        S_PROGRAM: begin
          if (ev[2]) begin
            state_q <= S_LOCKED;
            cnt_q   <= '0;
          end else if (dig_ev) begin
            tmr_q   <= '0;
            stage_q <= (CODE_LEN-1)'({stage_q, dig});
            if (cnt_q == LAST_DIG) begin
              code_q  <= {stage_q, dig};
              state_q <= S_LOCKED;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + DW'(1);
            end
          end else if (idle_to) begin
            state_q  <= S_UNLOCKED;
            unlock_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_LOCKOUT: begin
          if (lo_q == LO_LAST) begin
            state_q   <= S_LOCKED;
            lockout_q <= 1'b0;
            fcnt_q    <= '0;
          end else begin
            lo_q <= lo_q + LW'(1);
          end
        end
        default: state_q <= S_LOCKED;
      endcase
    end
  end

  assign UNLOCK_Output  = unlock_q;
  assign LOCKOUT_Output = lockout_q;
  assign FAIL_Pulse     = fail_q;
  assign DIGIT_Count    = cnt_q;

endmodule

// File: tb/tb_seq_lock_param.sv
// Directed bench for seq_lock_param: vector table of code entries
// plus hand-written lockout, program, timeout and reset sequences.
module tb_seq_lock_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       zb, ob, pb, lb;
  logic       unl, lko, fpl;
  logic [2:0] dcnt;

  int total = 0;
  int bad   = 0;
  int fail_mon = 0;
  int lo_mon   = 0;

  seq_lock_param dut (
    .clk           (clk),
    .RESET_Button  (rst),
    .ZERO_Button   (zb),
    .ONE_Button    (ob),
    .PROG_Button   (pb),
    .LOCK_Button   (lb),
    .UNLOCK_Output (unl),
    .LOCKOUT_Output(lko),
    .FAIL_Pulse    (fpl),
    .DIGIT_Count   (dcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fpl) fail_mon <= fail_mon + 1;
    if (lko) lo_mon   <= lo_mon + 1;
  end

  typedef struct {
    logic [3:0] code;
    int         unl;
    int         fails;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input logic b, input int gap);
    if (b) ob = 1'b1;
    else   zb = 1'b1;
    tick(1);
    ob = 1'b0;
    zb = 1'b0;
    tick(gap);
  endtask

  task automatic enter(input logic [3:0] code, input string nm);
    for (int i = 3; i >= 0; i--) begin
      digit(code[i], 4);
      if (i > 0) chk({nm, "_dcnt"}, int'(dcnt), 4 - i);
    end
    chk({nm, "_dcnt_end"}, int'(dcnt), 0);
  endtask

  task automatic press_lock();
    lb = 1'b1;
    tick(1);
    lb = 1'b0;
    tick(3);
  endtask

  task automatic press_prog();
    pb = 1'b1;
    tick(1);
    pb = 1'b0;
    tick(3);
  endtask

  task automatic areset_check(input string nm);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({nm, "_unl"}, int'(unl), 0);
    chk({nm, "_lko"}, int'(lko), 0);
    chk({nm, "_fpl"}, int'(fpl), 0);
    chk({nm, "_dcnt"}, int'(dcnt), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, l0, k;
    tbl[0] = '{4'b0110, 1, 0};
    tbl[1] = '{4'b1111, 0, 1};
    tbl[2] = '{4'b0111, 0, 1};
    tbl[3] = '{4'b0110, 1, 0};
    tbl[4] = '{4'b1110, 0, 1};
    tbl[5] = '{4'b0010, 0, 1};
    tbl[6] = '{4'b0110, 1, 0};

    rst = 1'b1;
    zb = 1'b0; ob = 1'b0; pb = 1'b0; lb = 1'b0;
    tick(3);
    chk("rst_unl", int'(unl), 0);
    chk("rst_lko", int'(lko), 0);
    chk("rst_fpl", int'(fpl), 0);
    chk("rst_dcnt", int'(dcnt), 0);
    rst = 1'b0;
    tick(2);

    // Default code, exact unlock latency
    f0 = fail_mon;
    digit(1'b0, 4);
    digit(1'b1, 4);
    digit(1'b1, 4);
    chk("lat_dcnt3", int'(dcnt), 3);
    zb = 1'b1;
    chk("lat_pre", int'(unl), 0);
    tick(1);
    chk("lat_post", int'(unl), 1);
    zb = 1'b0;
    tick(4);
    chk("lat_dcnt0", int'(dcnt), 0);
    chk("lat_nofail", fail_mon - f0, 0);
    press_lock();
    chk("lat_relock", int'(unl), 0);

    for (int i = 0; i < 7; i++) begin
      f0 = fail_mon;
      enter(tbl[i].code, $sformatf("vec%0d", i));
      tick(2);
      chk($sformatf("vec%0d_unl", i), int'(unl), tbl[i].unl);
      chk($sformatf("vec%0d_fail", i), fail_mon - f0, tbl[i].fails);
      chk($sformatf("vec%0d_lko", i), int'(lko), 0);
      if (tbl[i].unl == 1) begin
        press_lock();
        chk($sformatf("vec%0d_relock", i), int'(unl), 0);
      end
    end

    // Three wrong entries -> 64-cycle lockout, held button not replayed
    f0 = fail_mon;
    enter(4'b1111, "lo1");
    enter(4'b1111, "lo2");
    chk("lo_pre_lko", int'(lko), 0);
    l0 = lo_mon;
    enter(4'b1111, "lo3");
    chk("lo_active", int'(lko), 1);
    chk("lo_fails", fail_mon - f0, 3);
    ob = 1'b1;
    k = 0;
    while (lko && k < 200) begin
      tick(1);
      k++;
    end
    chk("lo_ended", int'(k < 200), 1);
    chk("lo_len", lo_mon - l0, 64);
    tick(3);
    chk("lo_noreplay", int'(dcnt), 0);
    ob = 1'b0;
    tick(2);
    enter(4'b0110, "lo_after");
    chk("lo_unlock", int'(unl), 1);

    // Program 1001, then old code fails, new code unlocks
    press_prog();
    chk("pg_unl", int'(unl), 0);
    chk("pg_dcnt", int'(dcnt), 0);
    enter(4'b1001, "pg_load");
    tick(2);
    chk("pg_locked", int'(unl), 0);
    f0 = fail_mon;
    enter(4'b0110, "pg_old");
    tick(2);
    chk("pg_old_fail", fail_mon - f0, 1);
    chk("pg_old_unl", int'(unl), 0);
    enter(4'b1001, "pg_new");
    chk("pg_new_unl", int'(unl), 1);
    areset_check("pg_rst");
    enter(4'b0110, "pg_dflt");
    chk("pg_dflt_unl", int'(unl), 1);

    // Idle timeout mid-entry
    press_lock();
    f0 = fail_mon;
    digit(1'b0, 4);
    digit(1'b1, 4);
    chk("to_dcnt2", int'(dcnt), 2);
    tick(200);
    chk("to_still", int'(dcnt), 2);
    tick(100);
    chk("to_clear", int'(dcnt), 0);
    chk("to_unl", int'(unl), 0);
    chk("to_nofail", fail_mon - f0, 0);
    enter(4'b0110, "to_after");
    chk("to_unlock", int'(unl), 1);

    // Simultaneous edges ignored; held level counts once
    press_lock();
    digit(1'b0, 4);
    zb = 1'b1;
    ob = 1'b1;
    tick(1);
    zb = 1'b0;
    ob = 1'b0;
    tick(3);
    chk("both_ign", int'(dcnt), 1);
    ob = 1'b1;
    tick(20);
    ob = 1'b0;
    tick(3);
    chk("hold_once", int'(dcnt), 2);
    digit(1'b1, 4);
    chk("hold_dcnt3", int'(dcnt), 3);
    digit(1'b0, 4);
    chk("hold_unlock", int'(unl), 1);

    // Async reset mid-entry
    press_lock();
    digit(1'b0, 4);
    digit(1'b1, 4);
    chk("mr_dcnt2", int'(dcnt), 2);
    areset_check("mr_rst");
    enter(4'b0110, "mr_after");
    chk("mr_unlock", int'(unl), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
